// File: rtl/sobel_stream_top.sv
// Streaming 3x3 Sobel filter: raster pixels in, one magnitude/threshold/passthrough
// result per interior pixel out, two line buffers feed the window, 2-stage pipeline.
module sobel_stream_top #(
  parameter int PIX_W = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int CNT_W = 10
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CORE_RUN_I,
  input  logic [1:0]       MODE_I,
  input  logic [PIX_W-1:0] THRESH_I,
  input  logic [PIX_W-1:0] DATA_I,
  input  logic             DATA_EN_I,
  output logic [PIX_W-1:0] PIXEL_O,
  output logic             EN_O,
  output logic             BUSY_O,
  output logic             CORE_DONE_O
);

  localparam int STAGES = 2;
  localparam int GW     = PIX_W + 3;
  localparam int MW     = PIX_W + 4;
  localparam int AW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                         state, state_nxt;
  logic [CNT_W-1:0]               col, row;
  logic                           drain_cnt;
  logic [1:0]                     mode_q;
  logic [PIX_W-1:0]               thresh_q;
  logic [STAGES:1]                vld_pipe;
  logic                           acc, last_col, last_px, win_ok;
  logic [PIX_W-1:0]               lb0 [IMG_W];
  logic [PIX_W-1:0]               lb1 [IMG_W];
  logic [2:0][2:0][PIX_W-1:0]     p;
  logic signed [GW-1:0]           gx, gy;
  logic [GW-1:0]                  ax, ay;
  logic [MW-1:0]                  mag;
  logic [PIX_W-1:0]               sat, res;

  assign acc      = (state == RUN) && DATA_EN_I;
  assign last_col = (col == CNT_W'(IMG_W - 1));
  assign last_px  = last_col && (row == CNT_W'(IMG_H - 1));
  assign win_ok   = acc && (row >= CNT_W'(2)) && (col >= CNT_W'(2));

  always_comb begin
    state_nxt   = state;
    BUSY_O      = 1'b0;
    CORE_DONE_O = 1'b0;
    case (state)
      IDLE:  if (CORE_RUN_I) state_nxt = RUN;
      RUN: begin
        BUSY_O = 1'b1;
        if (acc && last_px) state_nxt = DRAIN;
      end
      DRAIN: begin
        BUSY_O = 1'b1;
        if (drain_cnt) state_nxt = DONE;
      end
      DONE: begin
        CORE_DONE_O = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      drain_cnt <= 1'b0;
      mode_q    <= '0;
      thresh_q  <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
      if (state == IDLE && CORE_RUN_I) begin
        col      <= '0;
        row      <= '0;
        mode_q   <= MODE_I;
        thresh_q <= THRESH_I;
      end else if (acc) begin
        col <= last_col ? '0 : col + 1'b1;
        if (last_col) row <= last_px ? '0 : row + 1'b1;
      end
    end
  end

  // Window and line buffers carry no reset: the interior-only valid rule keeps
  // anything left over from a previous frame out of the results.
  always_ff @(posedge CLK) begin
    if (acc) begin
      lb0[col[AW-1:0]] <= DATA_I;
      lb1[col[AW-1:0]] <= lb0[col[AW-1:0]];
      for (int r = 0; r < 3; r++) begin
        p[r][0] <= p[r][1];
        p[r][1] <= p[r][2];
      end
      p[0][2] <= lb1[col[AW-1:0]];
      p[1][2] <= lb0[col[AW-1:0]];
      p[2][2] <= DATA_I;
    end
  end

  function automatic logic signed [GW-1:0] sx(input logic [PIX_W-1:0] v);
    return $signed({3'b000, v});
  endfunction

  always_comb begin
    gx  = (sx(p[0][2]) + (sx(p[1][2]) <<< 1) + sx(p[2][2]))
        - (sx(p[0][0]) + (sx(p[1][0]) <<< 1) + sx(p[2][0]));
    gy  = (sx(p[2][0]) + (sx(p[2][1]) <<< 1) + sx(p[2][2]))
        - (sx(p[0][0]) + (sx(p[0][1]) <<< 1) + sx(p[0][2]));
    ax  = gx[GW-1] ? $unsigned(-gx) : $unsigned(gx);
    ay  = gy[GW-1] ? $unsigned(-gy) : $unsigned(gy);
    mag = {1'b0, ax} + {1'b0, ay};
    sat = (|mag[MW-1:PIX_W]) ? '1 : mag[PIX_W-1:0];
    case (mode_q)
      2'd1:    res = (mag >= MW'(thresh_q)) ? '1 : '0;
      2'd2:    res = p[1][1];
      default: res = sat;
    endcase
  end

  // Stage 1 is the window register itself; stage 2 registers the result.
  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_pipe <= '0;
      PIXEL_O  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], win_ok};
      if (vld_pipe[1]) PIXEL_O <= res;
    end
  end

  assign EN_O = vld_pipe[STAGES];

endmodule
